// File: rtl/gru_seq_ctrl.sv
// Sequencer that steps a GRU cell over up to MAX_SEQ timesteps, feeding h_t back as h_t_prev.
// Optional WAIT watchdog is compiled in with `define GRU_SEQ_TIMEOUT_EN.
module gru_seq_ctrl #(
  parameter int unsigned D              = 64,
  parameter int unsigned H              = 16,
  parameter int unsigned DATA_WIDTH     = 15,
  parameter int unsigned MAX_SEQ        = 256,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  localparam int unsigned StepW         = $clog2(MAX_SEQ + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [StepW-1:0]        seq_len_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    x_rd_en_o,
  output logic [StepW-1:0]        x_rd_addr_o,
  input  logic [D*DATA_WIDTH-1:0] x_rd_data_i,
  output logic                    cell_start_o,
  input  logic                    cell_done_i,
  input  logic [H*DATA_WIDTH-1:0] cell_h_t_i,
  output logic [D*DATA_WIDTH-1:0] x_t_o,
  output logic [H*DATA_WIDTH-1:0] h_t_prev_o,
  output logic [H*DATA_WIDTH-1:0] h_out_o,
  output logic                    h_out_valid_o,
  input  logic                    h_out_ready_i,
  output logic [StepW-1:0]        step_idx_o,
  output logic                    timeout_err_o
);

  localparam logic [StepW-1:0] StepOne = StepW'(1);
  localparam logic [StepW-1:0] MaxLen  = StepW'(MAX_SEQ);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StRun,
    StWait,
    StEmit,
    StFin
  } state_e;

  state_e state_q, state_d;

  logic [StepW-1:0]        len_q, len_d;
  logic [StepW-1:0]        step_q, step_d;
  logic [D*DATA_WIDTH-1:0] x_t_q, x_t_d;
  logic [H*DATA_WIDTH-1:0] h_prev_q, h_prev_d;
  logic [H*DATA_WIDTH-1:0] h_out_q, h_out_d;

  logic [StepW-1:0] len_clamped;
  logic             last_step;
  logic             start_acc;
  logic             wait_expired;

  assign len_clamped = (seq_len_i > MaxLen) ? MaxLen : seq_len_i;
  assign last_step   = ((step_q + StepOne) == len_q);
  assign start_acc   = (state_q == StIdle) && start_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = (len_clamped == '0) ? StFin : StFetch;
        end
      end
      StFetch: state_d = StLoad;
      StLoad:  state_d = StRun;
      StRun:   state_d = StWait;
      StWait: begin
        if (cell_done_i) begin
          state_d = StEmit;
        end else if (wait_expired) begin
          state_d = StFin;
        end
      end
      StEmit: begin
        if (h_out_ready_i) begin
          state_d = last_step ? StFin : StFetch;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs
  always_comb begin
    busy_o        = (state_q != StIdle);
    done_o        = (state_q == StFin);
    x_rd_en_o     = (state_q == StFetch);
    cell_start_o  = (state_q == StRun);
    h_out_valid_o = (state_q == StEmit);
    x_rd_addr_o   = step_q;
    step_idx_o    = step_q;
    x_t_o         = x_t_q;
    h_t_prev_o    = h_prev_q;
    h_out_o       = h_out_q;
  end

  // Datapath next-state
  always_comb begin
    len_d    = len_q;
    step_d   = step_q;
    x_t_d    = x_t_q;
    h_prev_d = h_prev_q;
    h_out_d  = h_out_q;
    if (start_acc) begin
      len_d    = len_clamped;
      step_d   = '0;
      h_prev_d = '0;
    end
    if (state_q == StLoad) begin
      x_t_d = x_rd_data_i;
    end
    if ((state_q == StWait) && cell_done_i) begin
      h_out_d  = cell_h_t_i;
      h_prev_d = cell_h_t_i;
    end
    if ((state_q == StEmit) && h_out_ready_i && !last_step) begin
      step_d = step_q + StepOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q    <= '0;
      step_q   <= '0;
      x_t_q    <= '0;
      h_prev_q <= '0;
      h_out_q  <= '0;
    end else begin
      len_q    <= len_d;
      step_q   <= step_d;
      x_t_q    <= x_t_d;
      h_prev_q <= h_prev_d;
      h_out_q  <= h_out_d;
    end
  end

`ifdef GRU_SEQ_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tmo_q, tmo_d;

  // Expires on the WAIT cycle that would make the count reach TIMEOUT_CYCLES
  assign wait_expired = (state_q == StWait) && !cell_done_i && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    tmo_d = tmo_q;
    if (state_q == StRun) begin
      cnt_d = '0;
    end else if ((state_q == StWait) && !cell_done_i) begin
      cnt_d = cnt_q + CntOne;
    end
    if (start_acc) begin
      tmo_d = 1'b0;
    end else if (wait_expired) begin
      tmo_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout_err_o = tmo_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign wait_expired       = 1'b0;
  assign timeout_err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_gru_seq_ctrl.sv
// Directed bench for gru_seq_ctrl with a fixed-latency cell model and an x buffer model.
module tb_gru_seq_ctrl;

  localparam int D      = 4;
  localparam int H      = 3;
  localparam int W      = 8;
  localparam int MaxSeq = 8;
  localparam int Tmo    = 16;
  localparam int StepW  = $clog2(MaxSeq + 1);

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             start_i = 1'b0;
  logic [StepW-1:0] seq_len_i = '0;
  logic             busy_o, done_o, x_rd_en_o, cell_start_o, h_out_valid_o, timeout_err_o;
  logic [StepW-1:0] x_rd_addr_o, step_idx_o;
  logic [D*W-1:0]   x_rd_data_i = '0;
  logic             cell_done_i = 1'b0;
  logic [H*W-1:0]   cell_h_t_i = '0;
  logic [D*W-1:0]   x_t_o;
  logic [H*W-1:0]   h_t_prev_o, h_out_o;
  logic             h_out_ready_i = 1'b1;

  int errors = 0;
  int checks = 0;

  // Cell model controls (written only by the main sequence)
  logic cell_en  = 1'b1;
  int   cell_lat = 10;

  logic [H*W-1:0]   hout_q[$];
  logic [H*W-1:0]   hprev_q[$];
  logic [D*W-1:0]   xt_q[$];
  logic [StepW-1:0] addr_q[$];
  int               done_cnt = 0;

  gru_seq_ctrl #(
    .D              (D),
    .H              (H),
    .DATA_WIDTH     (W),
    .MAX_SEQ        (MaxSeq),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .seq_len_i      (seq_len_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .x_rd_en_o      (x_rd_en_o),
    .x_rd_addr_o    (x_rd_addr_o),
    .x_rd_data_i    (x_rd_data_i),
    .cell_start_o   (cell_start_o),
    .cell_done_i    (cell_done_i),
    .cell_h_t_i     (cell_h_t_i),
    .x_t_o          (x_t_o),
    .h_t_prev_o     (h_t_prev_o),
    .h_out_o        (h_out_o),
    .h_out_valid_o  (h_out_valid_o),
    .h_out_ready_i  (h_out_ready_i),
    .step_idx_o     (step_idx_o),
    .timeout_err_o  (timeout_err_o)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [D*W-1:0] xvec(input int addr);
    logic [D*W-1:0] r;
    for (int l = 0; l < D; l++) r[l*W +: W] = W'(addr * 8 + l);
    return r;
  endfunction

  function automatic logic [H*W-1:0] hvec(input int v);
    logic [H*W-1:0] r;
    for (int l = 0; l < H; l++) r[l*W +: W] = W'(v);
    return r;
  endfunction

  // x buffer + cell: h = (x lane0 / 8) + 1 in every lane, i.e. step + 1
  initial begin
    int cnt;
    int pend;
    cnt = 0;
    pend = 0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        cnt = 0;
        cell_done_i = 1'b0;
      end else begin
        cell_done_i = 1'b0;
        if (x_rd_en_o) x_rd_data_i = xvec(int'(x_rd_addr_o));
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            cell_done_i = 1'b1;
            cell_h_t_i  = hvec(pend);
          end
        end
        if (cell_start_o && cell_en) begin
          cnt  = cell_lat;
          pend = int'(x_t_o[W-1:0]) / 8 + 1;
        end
      end
    end
  end

  // Event monitor
  initial forever begin
    @(negedge clk);
    if (rst_ni) begin
      if (x_rd_en_o) addr_q.push_back(x_rd_addr_o);
      if (cell_start_o) begin
        hprev_q.push_back(h_t_prev_o);
        xt_q.push_back(x_t_o);
      end
      if (h_out_valid_o && h_out_ready_i) hout_q.push_back(h_out_o);
      if (done_o) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the accepting edge (cycle 1)
  task automatic start_seq(input int n);
    @(posedge clk);
    #1 start_i = 1'b1;
    seq_len_i = StepW'(n);
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (!done_o && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (done_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_seen: no done within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) tick();
    checks++;
    if ({busy_o, done_o, x_rd_en_o, x_rd_addr_o, cell_start_o, x_t_o, h_t_prev_o, h_out_o,
         h_out_valid_o, step_idx_o, timeout_err_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b rd=%b hv=%b got nonzero, want all 0",
               busy_o, done_o, x_rd_en_o, h_out_valid_o);
    end
    rst_ni = 1'b1;
    repeat (2) tick();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b want 0", busy_o);
    end
  endtask

  task automatic test_basic();
    int ha, aa, pa, d0;
    ha = hout_q.size(); aa = addr_q.size(); pa = hprev_q.size(); d0 = done_cnt;
    cell_lat = 10;
    h_out_ready_i = 1'b1;
    start_seq(3);
    checks++;
    if ({busy_o, x_rd_en_o, x_rd_addr_o} !== {1'b1, 1'b1, StepW'(0)}) begin
      errors++;
      $display("FAIL basic_cycle1: busy=%b rd_en=%b addr=%0d want 1 1 0", busy_o, x_rd_en_o,
               x_rd_addr_o);
    end
    tick();
    checks++;
    if ({x_rd_en_o, cell_start_o} !== 2'b00) begin
      errors++;
      $display("FAIL basic_cycle2: rd_en=%b cell_start=%b want 0 0", x_rd_en_o, cell_start_o);
    end
    tick();
    checks++;
    if (cell_start_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_cycle3_cell_start: got %b want 1", cell_start_o);
    end
    wait_done(200, "basic");
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_at_done: got %b want 1", busy_o);
    end
    tick();
    checks++;
    if ({busy_o, done_o} !== 2'b00) begin
      errors++;
      $display("FAIL basic_after_done: busy=%b done=%b want 0 0", busy_o, done_o);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0);
    end
    checks++;
    if (hout_q.size() - ha != 3 || addr_q.size() - aa != 3 || hprev_q.size() - pa != 3) begin
      errors++;
      $display("FAIL basic_counts: hout=%0d addr=%0d start=%0d want 3 3 3",
               hout_q.size() - ha, addr_q.size() - aa, hprev_q.size() - pa);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (hout_q[ha+k] !== hvec(k + 1)) begin
          errors++;
          $display("FAIL basic_hout[%0d]: got %h want %h", k, hout_q[ha+k], hvec(k + 1));
        end
        checks++;
        if (addr_q[aa+k] !== StepW'(k)) begin
          errors++;
          $display("FAIL basic_addr[%0d]: got %0d want %0d", k, addr_q[aa+k], k);
        end
        checks++;
        if (hprev_q[pa+k] !== hvec(k) || xt_q[pa+k] !== xvec(k)) begin
          errors++;
          $display("FAIL basic_cell_inputs[%0d]: hprev=%h x=%h want %h %h", k, hprev_q[pa+k],
                   xt_q[pa+k], hvec(k), xvec(k));
        end
      end
    end
    checks++;
    if (timeout_err_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_timeout_err: got %b want 0", timeout_err_o);
    end
  endtask

  task automatic test_zero_len();
    int aa, pa;
    aa = addr_q.size(); pa = hprev_q.size();
    start_seq(0);
    checks++;
    if ({done_o, busy_o} !== 2'b11) begin
      errors++;
      $display("FAIL zero_len_fin: done=%b busy=%b want 1 1", done_o, busy_o);
    end
    tick();
    checks++;
    if ({done_o, busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL zero_len_idle: done=%b busy=%b want 0 0", done_o, busy_o);
    end
    checks++;
    if (addr_q.size() != aa || hprev_q.size() != pa) begin
      errors++;
      $display("FAIL zero_len_no_activity: reads=%0d starts=%0d want 0 0",
               addr_q.size() - aa, hprev_q.size() - pa);
    end
  endtask

  task automatic test_backpressure();
    int ha, n;
    logic [H*W-1:0] snap;
    ha = hout_q.size();
    h_out_ready_i = 1'b0;
    start_seq(2);
    n = 0;
    while (!h_out_valid_o && n < 50) begin
      tick();
      n++;
    end
    snap = h_out_o;
    checks++;
    if (h_out_valid_o !== 1'b1 || snap !== hvec(1)) begin
      errors++;
      $display("FAIL bp_first_valid: valid=%b h=%h want 1 %h", h_out_valid_o, snap, hvec(1));
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if ({h_out_valid_o, x_rd_en_o} !== 2'b10 || h_out_o !== snap) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b rd_en=%b h=%h want 1 0 %h", i, h_out_valid_o,
                 x_rd_en_o, h_out_o, snap);
      end
      tick();
    end
    h_out_ready_i = 1'b1;
    wait_done(200, "bp");
    tick();
    checks++;
    if (hout_q.size() - ha != 2) begin
      errors++;
      $display("FAIL bp_transfers: got %0d want 2", hout_q.size() - ha);
    end else begin
      checks++;
      if (hout_q[ha] !== hvec(1) || hout_q[ha+1] !== hvec(2)) begin
        errors++;
        $display("FAIL bp_values: got %h %h want %h %h", hout_q[ha], hout_q[ha+1], hvec(1),
                 hvec(2));
      end
    end
  endtask

  task automatic test_start_ignored();
    int ha, d0, n;
    ha = hout_q.size(); d0 = done_cnt;
    start_seq(2);
    n = 0;
    while (!cell_start_o && n < 10) begin
      tick();
      n++;
    end
    tick();
    start_i = 1'b1;
    seq_len_i = StepW'(5);
    tick();
    start_i = 1'b0;
    wait_done(300, "restart");
    tick();
    checks++;
    if (hout_q.size() - ha != 2 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL restart_ignored: transfers=%0d dones=%0d want 2 1", hout_q.size() - ha,
               done_cnt - d0);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL restart_idle_busy: got %b want 0", busy_o);
    end
  endtask

  task automatic test_reset_mid();
    int pa, n, d0, ha;
    pa = hprev_q.size();
    start_seq(3);
    n = 0;
    while (hprev_q.size() < pa + 2 && n < 100) begin
      tick();
      n++;
    end
    tick();
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, x_rd_en_o, x_rd_addr_o, cell_start_o, x_t_o, h_t_prev_o, h_out_o,
         h_out_valid_o, step_idx_o, timeout_err_o} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: busy=%b step=%0d hprev=%h got nonzero, want all 0",
               busy_o, step_idx_o, h_t_prev_o);
    end
    d0 = done_cnt;
    repeat (2) tick();
    rst_ni = 1'b1;
    repeat (3) tick();
    checks++;
    if (done_cnt != d0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_done: dones=%0d busy=%b want 0 0", done_cnt - d0, busy_o);
    end
    ha = hout_q.size(); pa = hprev_q.size();
    start_seq(1);
    checks++;
    if ({x_rd_en_o, x_rd_addr_o, step_idx_o} !== {1'b1, StepW'(0), StepW'(0)}) begin
      errors++;
      $display("FAIL midreset_restart_fetch: rd_en=%b addr=%0d step=%0d want 1 0 0",
               x_rd_en_o, x_rd_addr_o, step_idx_o);
    end
    wait_done(200, "midreset");
    tick();
    checks++;
    if (hout_q.size() - ha != 1 || hprev_q.size() - pa != 1) begin
      errors++;
      $display("FAIL midreset_counts: transfers=%0d starts=%0d want 1 1", hout_q.size() - ha,
               hprev_q.size() - pa);
    end else begin
      checks++;
      if (hout_q[ha] !== hvec(1) || hprev_q[pa] !== '0) begin
        errors++;
        $display("FAIL midreset_values: h=%h hprev=%h want %h 0", hout_q[ha], hprev_q[pa],
                 hvec(1));
      end
    end
  endtask

  task automatic test_clamp();
    int ha, aa;
    ha = hout_q.size(); aa = addr_q.size();
    cell_lat = 3;
    start_seq(15);
    wait_done(500, "clamp");
    tick();
    checks++;
    if (hout_q.size() - ha != MaxSeq) begin
      errors++;
      $display("FAIL clamp_transfers: got %0d want %0d", hout_q.size() - ha, MaxSeq);
    end else begin
      checks++;
      if (hout_q[ha+MaxSeq-1] !== hvec(MaxSeq) || addr_q[aa+MaxSeq-1] !== StepW'(MaxSeq - 1))
      begin
        errors++;
        $display("FAIL clamp_last: h=%h addr=%0d want %h %0d", hout_q[ha+MaxSeq-1],
                 addr_q[aa+MaxSeq-1], hvec(MaxSeq), MaxSeq - 1);
      end
    end
    cell_lat = 10;
  endtask

  task automatic test_timeout();
    int n, ha;
    ha = hout_q.size();
    cell_en = 1'b0;
    start_seq(2);
    n = 0;
    while (!cell_start_o && n < 10) begin
      tick();
      n++;
    end
`ifdef GRU_SEQ_TIMEOUT_EN
    tick();
    n = 0;
    while (!done_o && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != Tmo) begin
      errors++;
      $display("FAIL timeout_latency: done %0d cycles after WAIT entry, want %0d", n, Tmo);
    end
    checks++;
    if ({timeout_err_o, busy_o} !== 2'b11) begin
      errors++;
      $display("FAIL timeout_flag: err=%b busy=%b want 1 1", timeout_err_o, busy_o);
    end
    tick();
    checks++;
    if ({timeout_err_o, busy_o} !== 2'b10 || hout_q.size() != ha) begin
      errors++;
      $display("FAIL timeout_sticky: err=%b busy=%b transfers=%0d want 1 0 0", timeout_err_o,
               busy_o, hout_q.size() - ha);
    end
    cell_en = 1'b1;
    start_seq(1);
    checks++;
    if (timeout_err_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear_on_start: got %b want 0", timeout_err_o);
    end
    wait_done(200, "timeout_recover");
    tick();
`else
    repeat (40) tick();
    checks++;
    if ({busy_o, timeout_err_o, done_o} !== 3'b100 || hout_q.size() != ha) begin
      errors++;
      $display("FAIL stall_waits: busy=%b err=%b done=%b want 1 0 0", busy_o, timeout_err_o,
               done_o);
    end
    rst_ni = 1'b0;
    repeat (2) tick();
    rst_ni = 1'b1;
    cell_en = 1'b1;
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_clamp();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
